// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multi-cycle load/store unit with lane steering, extension and bus timeout
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              stall,
    output logic              Bus_req,
    output logic              Bus_wen,
    output logic [ADDR_W-1:0] Bus_addr,
    output logic [3:0]        Bus_be,
    output logic [31:0]       Bus_wdata,
    input  logic              Bus_ack,
    input  logic [31:0]       Bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_MIS  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;
    localparam logic [1:0] ERR_SIZE = 2'b11;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_err;

    logic              w_accept;
    logic              w_timeout;
    logic [1:0]        w_req_err;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_lane;
    logic [31:0]       w_load;

    assign w_accept  = (r_state == S_IDLE) && req_valid;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_req_err = ERR_OK;
        w_be      = 4'b0000;
        w_wdata   = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be      = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{req_wdata[15:0]}};
                w_req_err = req_addr[0] ? ERR_MIS : ERR_OK;
            end
            2'b10: begin
                w_be      = 4'b1111;
                w_req_err = (req_addr[1:0] != 2'b00) ? ERR_MIS : ERR_OK;
            end
            default: w_req_err = ERR_SIZE;
        endcase
    end

    // The addressed lane is shifted down to bit 0 before extension.
    always_comb begin
        w_lane = Bus_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'b00:   w_load = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
            2'b01:   w_load = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
            default: w_load = w_lane;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = (w_req_err != ERR_OK) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (Bus_ack || w_timeout) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wdata <= 32'd0;
            r_cnt   <= '0;
            r_rdata <= 32'd0;
            r_err   <= ERR_OK;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_uns   <= req_unsigned;
                r_addr  <= req_addr;
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_cnt   <= '0;
                if (w_req_err != ERR_OK) begin
                    r_err   <= w_req_err;
                    r_rdata <= 32'd0;
                end
            end
            if (r_state == S_ACCESS) begin
                if (Bus_ack) begin
                    r_err   <= ERR_OK;
                    r_rdata <= r_we ? 32'd0 : w_load;
                end else if (w_timeout) begin
                    r_err   <= ERR_TMO;
                    r_rdata <= 32'd0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign stall     = ~req_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign Bus_req   = (r_state == S_ACCESS);
    assign Bus_wen   = Bus_req & r_we;
    assign Bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign Bus_be    = r_be;
    assign Bus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int TIMEOUT = 16;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        stall;
    logic        Bus_req;
    logic        Bus_wen;
    logic [31:0] Bus_addr;
    logic [3:0]  Bus_be;
    logic [31:0] Bus_wdata;
    logic        Bus_ack = 1'b0;
    logic [31:0] Bus_rdata = 32'd0;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .stall(stall), .Bus_req(Bus_req), .Bus_wen(Bus_wen),
        .Bus_addr(Bus_addr), .Bus_be(Bus_be), .Bus_wdata(Bus_wdata),
        .Bus_ack(Bus_ack), .Bus_rdata(Bus_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] size, input logic uns,
                                                input logic [31:0] addr, input logic [31:0] word);
        longint v;
        longint bits;
        if (size == 2'd2) return word;
        bits = 8 * (1 << size);
        v = longint'(word) / (longint'(1) << (8 * (addr % 4)));
        v = v % (longint'(1) << bits);
        if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] word, input int waits);
        int          nb;
        logic [1:0]  e_err;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        int          e_lat;
        int          e_busc;
        int          lat;
        int          busc;
        int          bad;
        logic        got;
        logic [31:0] g_rd;
        logic [1:0]  g_err;

        nb = 1 << size;
        if (size == 2'd3) e_err = 2'd3;
        else if (addr % nb != 0) e_err = 2'd1;
        else if (waits >= TIMEOUT) e_err = 2'd2;
        else e_err = 2'd0;
        e_be = 4'(((1 << nb) - 1) << (addr % 4));
        for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = 8'(wd >> (8 * (i % nb)));
        e_rd = (e_err != 0 || we) ? 32'd0 : model_rdata(size, uns, addr, word);
        case (e_err)
            2'd0:    begin e_lat = 2 + waits;   e_busc = waits + 1; end
            2'd2:    begin e_lat = 1 + TIMEOUT; e_busc = TIMEOUT;   end
            default: begin e_lat = 1;           e_busc = 0;         end
        endcase

        @(negedge cpu_clk);
        check("ready_idle", req_ready, 1'b1);
        check("stall_idle", stall, 1'b0);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        Bus_ack = 1'b0;
        @(posedge cpu_clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; busc = 0; bad = 0; got = 1'b0; g_rd = 32'd0; g_err = 2'd0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge cpu_clk);
            if (!stall) bad++;
            if (Bus_req) begin
                busc++;
                if (busc == 1) begin
                    check("bus_addr", Bus_addr, {addr[31:2], 2'b00});
                    check("bus_be", Bus_be, e_be);
                    check("bus_wen", Bus_wen, we);
                    if (we) check("bus_wdata", Bus_wdata, e_wd);
                end else if (Bus_addr !== {addr[31:2], 2'b00} || Bus_be !== e_be ||
                             Bus_wen !== we || (we && Bus_wdata !== e_wd)) begin
                    bad++;
                end
                Bus_ack   = (busc - 1 == waits);
                Bus_rdata = Bus_ack ? word : $urandom;
            end else begin
                Bus_ack = 1'b0;
            end
            if (rsp_valid) begin
                got = 1'b1; lat = c; g_rd = rsp_rdata; g_err = rsp_err;
            end
            if (!got) @(posedge cpu_clk);
        end
        check("rsp_seen", got, 1'b1);
        check("latency", lat, e_lat);
        check("bus_cycles", busc, e_busc);
        check("rsp_err", g_err, e_err);
        check("rsp_rdata", g_rd, e_rd);
        check("stable", bad, 0);
        @(negedge cpu_clk);
        check("rsp_pulse", rsp_valid, 1'b0);
        check("rdata_held", rsp_rdata, e_rd);
        check("err_held", rsp_err, e_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int seen;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          w;

        #2;
        check("rst_ready", req_ready, 1'b1);
        check("rst_stall", stall, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", rsp_err, 2'd0);
        check("rst_bus_req", Bus_req, 1'b0);
        check("rst_bus_wen", Bus_wen, 1'b0);
        check("rst_bus_addr", Bus_addr, 32'd0);
        check("rst_bus_be", Bus_be, 4'd0);
        check("rst_bus_wdata", Bus_wdata, 32'd0);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;

        run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        run_op(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80000000, 3);
        check("lb_signed", rsp_rdata, 32'hFFFFFF80);
        run_op(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80000000, 3);
        check("lbu", rsp_rdata, 32'h00000080);
        run_op(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234ABCD, 32'h55AA55AA, 2);
        run_op(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        run_op(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        run_op(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'hFFFFFFFF, 1000);
        run_op(1'b0, 2'd1, 1'b0, 32'h106, 32'h0, 32'h8001_7FFF, TIMEOUT - 1);

        @(negedge cpu_clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100;
        req_valid = 1'b1; Bus_ack = 1'b0;
        @(posedge cpu_clk);
        #1 req_valid = 1'b0;
        @(negedge cpu_clk);
        check("midrst_acc1", Bus_req, 1'b1);
        @(negedge cpu_clk);
        check("midrst_acc2", Bus_req, 1'b1);
        #1 cpu_rst = 1'b0;
        #1;
        check("midrst_bus_req", Bus_req, 1'b0);
        check("midrst_rsp", rsp_valid, 1'b0);
        check("midrst_ready", req_ready, 1'b1);
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge cpu_clk);
            seen += int'(rsp_valid);
        end
        check("midrst_no_rsp", seen, 0);
        check("midrst_ready_after", req_ready, 1'b1);

        for (int n = 0; n < 250; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 1) == 0) ad[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) w = TIMEOUT - 1 + $urandom_range(0, 3);
            else w = $urandom_range(0, 5);
            run_op(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom, w);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
